// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the write-back entry type for the register-file write arbiter.
package regfile_wb_arbiter_pkg;
    localparam int DEPTH_DEF        = 4;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int REG_ADDR_W       = 5;
    localparam int XLEN             = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Long-latency result buffer; storage and per-entry valid bits are exported for the hazard scan.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  wb_entry_t               push_entry_i,
    input  logic                    pop_i,
    output wb_entry_t               head_o,
    output wb_entry_t [DEPTH-1:0]   mem_o,
    output logic [DEPTH-1:0]        valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_ONE = 1;
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      valid_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign mem_o   = mem_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

    // Push and pop never touch the same slot: both need the buffer neither full nor empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q]   <= push_entry_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and buffered long-latency (B) results onto one registered register-file write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [REG_ADDR_W-1:0]   a_rd,
    input  logic [XLEN-1:0]         a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [REG_ADDR_W-1:0]   b_rd,
    input  logic [XLEN-1:0]         b_data,
    input  logic [REG_ADDR_W-1:0]   q_rd,
    output logic                    q_pend,
    output logic [REG_ADDR_W-1:0]   A3,
    output logic [XLEN-1:0]         WD3,
    output logic                    WE3,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             push_entry, head;
    wb_entry_t [DEPTH-1:0] fifo_mem;
    logic [DEPTH-1:0]      fifo_valid;
    logic                  fifo_full, fifo_empty;
    logic                  a_fire, a_write, b_fire, push, pop, q_hit;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  we3_q, we3_d;
    logic [REG_ADDR_W-1:0] a3_q, a3_d;
    logic [XLEN-1:0]       wd3_q, wd3_d;

    assign a_ready = (starve_q != SW'(STARVE_LIMIT));
    assign b_ready = ~fifo_full;
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_valid & b_ready;
    // x0 results complete the handshake but never reach the buffer or the write port.
    assign a_write = a_fire & (a_rd != '0);
    assign push    = b_fire & (b_rd != '0);
    assign pop     = ~a_fire & ~fifo_empty;

    assign push_entry.rd   = b_rd;
    assign push_entry.data = b_data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .mem_o        (fifo_mem),
        .valid_o      (fifo_valid),
        .count_o      (count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (a_fire) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (a_write) begin
            we3_d = 1'b1;
            a3_d  = a_rd;
            wd3_d = a_data;
        end else if (pop) begin
            we3_d = 1'b1;
            a3_d  = head.rd;
            wd3_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            starve_q <= starve_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

    // A write sitting in the output register is still pending until the file captures it.
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_mem[i].rd == q_rd)) q_hit = 1'b1;
        end
        if (we3_q && (a3_q == q_rd)) q_hit = 1'b1;
        q_pend = (q_rd != '0) & q_hit;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench: stimulus queues expected writes, a negedge monitor checks the write port.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready, q_pend, WE3;
    logic [4:0]  a_rd = '0, b_rd = '0, q_rd = '0, A3;
    logic [31:0] a_data = '0, b_data = '0, WD3;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .q_rd    (q_rd),
        .q_pend  (q_pend),
        .A3      (A3),
        .WD3     (WD3),
        .WE3     (WE3),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && WE3) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got rd=%0d data=%0h, expected no write", A3, WD3);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (A3 !== e.rd || WD3 !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                             A3, WD3, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        int bi;
        logic saw_full;
        logic [6:0] starve_pat;

        // Reset state
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_we3", WE3, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // A only: one-cycle latency
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("a_only_ready", a_ready, 1);
        push_exp(5'd5, 32'hDEADBEEF);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("a_only_we3", WE3, 1);
        chk("a_only_a3", A3, 5);
        tick();

        // B only: two-cycle latency, hazard visible in buffer and output register
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h11;
        @(negedge clk);
        chk("b_only_ready", b_ready, 1);
        push_exp(5'd7, 32'h11);
        tick();
        b_valid = 1'b0; q_rd = 5'd7;
        @(negedge clk);
        chk("b_lat_not1_we3", WE3, 0);
        chk("b_qpend_fifo", q_pend, 1);
        tick();
        @(negedge clk);
        chk("b_lat2_we3", WE3, 1);
        chk("b_lat2_a3", A3, 7);
        chk("b_qpend_outreg", q_pend, 1);
        q_rd = 5'd0;
        #1 chk("b_qpend_x0", q_pend, 0);
        q_rd = 5'd7;
        tick();
        @(negedge clk);
        chk("b_qpend_cleared", q_pend, 0);
        tick();

        // Fill buffer while A (x0) holds the port; fifth B must be held, then accepted
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
        bi = 0; saw_full = 1'b0;
        for (int c = 0; c < 60 && bi < 5; c++) begin
            b_valid = 1'b1; b_rd = 5'(10 + bi); b_data = 32'h100 + 32'(bi);
            @(negedge clk);
            if (count == 3'd4 && !b_ready) saw_full = 1'b1;
            if (b_ready) begin
                push_exp(b_rd, b_data);
                bi++;
            end
            tick();
        end
        b_valid = 1'b0; a_valid = 1'b0;
        chk("fill_full_seen", {31'd0, saw_full}, 1);
        chk("fill_fifth_accepted", bi, 5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (count == 3'd0) break;
            tick();
        end
        chk("fill_drained", count, 0);
        repeat (3) tick();

        // Starvation: one buffered entry, A held high
        starve_pat = 7'b101_1111;
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1; a_rd = 5'(i + 1); a_data = 32'hA000 + 32'(i);
            b_valid = (i == 0); b_rd = 5'd9; b_data = 32'h99;
            @(negedge clk);
            chk("starve_a_ready", {31'd0, a_ready}, {31'd0, starve_pat[i]});
            if (starve_pat[i]) push_exp(a_rd, a_data);
            else push_exp(5'd9, 32'h99);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) tick();

        // x0 on both ports
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("x0_count", count, 0);
            chk("x0_we3", WE3, 0);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) tick();

        // Async reset with three entries buffered
        a_valid = 1'b1; a_rd = 5'd0;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_rd = 5'(20 + i); b_data = 32'h200 + 32'(i);
            tick();
        end
        b_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_we3", WE3, 0);
        chk("async_rst_b_ready", b_ready, 1);
        chk("async_rst_a_ready", a_ready, 1);
        a_valid = 1'b0;
        for (int q = 0; q < 32; q++) begin
            q_rd = 5'(q);
            #1 chk("async_rst_qpend", q_pend, 0);
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_count", count, 0);
        chk("sb_empty_at_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
